// File: rtl/simframe_cfg_pkg.sv
// simframe_cfg_pkg: shared constants and types for the multi-channel simframe
// configuration block.
//   - Register indices (index = (addr & ADDR_MASK) >> 2)
//   - AXI response codes, module version, reset defaults
//   - ASHI handshake state encoding used by axi4_lite_slave
package simframe_cfg_pkg;

   localparam logic [31:0] MODULE_VERSION = 32'd2;

   localparam logic [1:0] RESP_OKAY   = 2'd0;
   localparam logic [1:0] RESP_SLVERR = 2'd2;
   localparam logic [1:0] RESP_DECERR = 2'd3;

   localparam logic [6:0] ADDR_MASK = 7'h7F;

   localparam logic [4:0] REG_MODULE_REV = 5'd0;
   localparam logic [4:0] REG_GEOMETRY   = 5'd1;
   localparam logic [4:0] REG_COMMIT     = 5'd2;
   localparam logic [4:0] REG_CHAN_SEL   = 5'd3;
   localparam logic [4:0] REG_FORCE      = 5'd4;
   localparam logic [4:0] REG_BPU        = 5'd12;
   localparam logic [4:0] REG_ACTIVE_BPU = 5'd13;
   localparam logic [4:0] REG_META_BASE  = 5'd16;

   localparam logic [63:0] DFLT_METADATA = 64'h0042_DEAD_BEEF_4200;
   localparam logic [31:0] DFLT_BPU      = 32'd12288;

   typedef enum logic [1:0] {
      ASHI_IDLE = 2'd0,
      ASHI_EXEC = 2'd1,
      ASHI_RESP = 2'd2
   } ashi_state_t;

   // Words 0/1 carry the 64-bit default, everything above resets to zero.
   function automatic logic [31:0] meta_default(input int w, input logic [63:0] dflt);
      case (w)
         0:       return dflt[31:0];
         1:       return dflt[63:32];
         default: return 32'd0;
      endcase
   endfunction

   function automatic int idx_bits(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/axi4_lite_slave.sv
// axi4_lite_slave: AXI4-Lite slave front end presenting the ASHI interface.
//   S_AXI_*      : AXI4-Lite slave, 32-bit address/data
//   ASHI_WADDR/ASHI_WDATA/ASHI_WRITE : one-cycle write strobe with address/data
//   ASHI_WRESP   : user write response, sampled in the ASHI_WRITE cycle
//   ASHI_RADDR/ASHI_READ             : one-cycle read strobe with address
//   ASHI_RDATA/ASHI_RRESP            : user registers them in the ASHI_READ cycle;
//                                      forwarded on R the following cycle
// AW and W are accepted together; the write and read sides are independent.
module axi4_lite_slave
   import simframe_cfg_pkg::*;
(
   input  logic        clk,
   input  logic        resetn,
   input  logic [31:0] S_AXI_AWADDR,
   input  logic        S_AXI_AWVALID,
   output logic        S_AXI_AWREADY,
   input  logic [31:0] S_AXI_WDATA,
   input  logic        S_AXI_WVALID,
   output logic        S_AXI_WREADY,
   output logic [1:0]  S_AXI_BRESP,
   output logic        S_AXI_BVALID,
   input  logic        S_AXI_BREADY,
   input  logic [31:0] S_AXI_ARADDR,
   input  logic        S_AXI_ARVALID,
   output logic        S_AXI_ARREADY,
   output logic [31:0] S_AXI_RDATA,
   output logic [1:0]  S_AXI_RRESP,
   output logic        S_AXI_RVALID,
   input  logic        S_AXI_RREADY,
   output logic [31:0] ASHI_WADDR,
   output logic [31:0] ASHI_WDATA,
   output logic        ASHI_WRITE,
   input  logic [1:0]  ASHI_WRESP,
   output logic [31:0] ASHI_RADDR,
   output logic        ASHI_READ,
   input  logic [31:0] ASHI_RDATA,
   input  logic [1:0]  ASHI_RRESP
);

   ashi_state_t wstate, wstate_nxt, rstate, rstate_nxt;
   logic [1:0]  bresp;

   // write side: state register
   always_ff @(posedge clk) begin
      if (!resetn) begin
         wstate     <= ASHI_IDLE;
         ASHI_WADDR <= '0;
         ASHI_WDATA <= '0;
         bresp      <= RESP_OKAY;
      end else begin
         wstate <= wstate_nxt;
         if (wstate == ASHI_IDLE && S_AXI_AWVALID && S_AXI_WVALID) begin
            ASHI_WADDR <= S_AXI_AWADDR;
            ASHI_WDATA <= S_AXI_WDATA;
         end
         if (wstate == ASHI_EXEC) bresp <= ASHI_WRESP;
      end
   end

   // write side: next state
   always_comb begin
      wstate_nxt = wstate;
      case (wstate)
         ASHI_IDLE: if (S_AXI_AWVALID && S_AXI_WVALID) wstate_nxt = ASHI_EXEC;
         ASHI_EXEC: wstate_nxt = ASHI_RESP;
         ASHI_RESP: if (S_AXI_BREADY) wstate_nxt = ASHI_IDLE;
         default:   wstate_nxt = ASHI_IDLE;
      endcase
   end

   // write side: outputs
   always_comb begin
      S_AXI_AWREADY = (wstate == ASHI_IDLE) && S_AXI_AWVALID && S_AXI_WVALID;
      S_AXI_WREADY  = S_AXI_AWREADY;
      ASHI_WRITE    = (wstate == ASHI_EXEC);
      S_AXI_BVALID  = (wstate == ASHI_RESP);
      S_AXI_BRESP   = bresp;
   end

   // read side: state register
   always_ff @(posedge clk) begin
      if (!resetn) begin
         rstate     <= ASHI_IDLE;
         ASHI_RADDR <= '0;
      end else begin
         rstate <= rstate_nxt;
         if (rstate == ASHI_IDLE && S_AXI_ARVALID) ASHI_RADDR <= S_AXI_ARADDR;
      end
   end

   // read side: next state
   always_comb begin
      rstate_nxt = rstate;
      case (rstate)
         ASHI_IDLE: if (S_AXI_ARVALID) rstate_nxt = ASHI_EXEC;
         ASHI_EXEC: rstate_nxt = ASHI_RESP;
         ASHI_RESP: if (S_AXI_RREADY) rstate_nxt = ASHI_IDLE;
         default:   rstate_nxt = ASHI_IDLE;
      endcase
   end

   // read side: outputs; user data is already registered and held stable
   always_comb begin
      S_AXI_ARREADY = (rstate == ASHI_IDLE) && S_AXI_ARVALID;
      ASHI_READ     = (rstate == ASHI_EXEC);
      S_AXI_RVALID  = (rstate == ASHI_RESP);
      S_AXI_RDATA   = ASHI_RDATA;
      S_AXI_RRESP   = ASHI_RRESP;
   end

endmodule

// File: rtl/simframe_cfg_chan.sv
// simframe_cfg_chan: one channel's staged and active settings.
//   meta_we/meta_widx/bpu_we/wdata : staged-copy writes from the register decode
//   do_copy   : active <= staged (whole channel) on this edge
//   stg_*     : staged copy (register readback)
//   act_*     : active copy (drives the generator)
//   committed : one-cycle pulse, high in the cycle the new active values appear
module simframe_cfg_chan
   import simframe_cfg_pkg::*;
#(
   parameter int          META_WORDS             = 16,
   parameter logic [63:0] DEFAULT_METADATA       = DFLT_METADATA,
   parameter logic [31:0] DEFAULT_BYTES_PER_USEC = DFLT_BPU,
   localparam int         MIW                    = idx_bits(META_WORDS)
) (
   input  logic                        clk,
   input  logic                        resetn,
   input  logic                        meta_we,
   input  logic [MIW-1:0]              meta_widx,
   input  logic                        bpu_we,
   input  logic [31:0]                 wdata,
   input  logic                        do_copy,
   output logic [META_WORDS-1:0][31:0] stg_meta,
   output logic [META_WORDS-1:0][31:0] act_meta,
   output logic [31:0]                 stg_bpu,
   output logic [31:0]                 act_bpu,
   output logic                        committed
);

   // Non-blocking copy: a staged write landing on the same edge as a copy
   // is not seen by active until the next commit.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         for (int w = 0; w < META_WORDS; w++) begin
            stg_meta[w] <= meta_default(w, DEFAULT_METADATA);
            act_meta[w] <= meta_default(w, DEFAULT_METADATA);
         end
         stg_bpu   <= DEFAULT_BYTES_PER_USEC;
         act_bpu   <= DEFAULT_BYTES_PER_USEC;
         committed <= 1'b0;
      end else begin
         if (meta_we) stg_meta[meta_widx] <= wdata;
         if (bpu_we)  stg_bpu <= wdata;
         if (do_copy) begin
            act_meta <= stg_meta;
            act_bpu  <= stg_bpu;
         end
         committed <= do_copy;
      end
   end

endmodule

// File: rtl/simframe_config_mc.sv
// simframe_config_mc: multi-channel double-buffered simframe configuration.
//   clk, resetn     : clock, synchronous active-low reset
//   S_AXI_*         : AXI4-Lite slave (32-bit)
//   FRAME_BOUNDARY  : per-channel boundary pulse; armed commits apply here
//   METADATA        : active metadata, ch c word w at [(c*META_WORDS+w)*32 +: 32]
//   BYTES_PER_USEC  : active throughput, ch c at [c*32 +: 32]
//   PENDING         : commit armed, not yet applied
//   COMMITTED       : one-cycle pulse with the new active values
// Build option: define SIMFRAME_CFG_FORCE_EN to add the write-only FORCE
// register (index 4) that copies immediately without waiting for a boundary.
module simframe_config_mc
   import simframe_cfg_pkg::*;
#(
   parameter int          NUM_CHANNELS           = 4,
   parameter int          META_WORDS             = 16,
   parameter logic [63:0] DEFAULT_METADATA       = DFLT_METADATA,
   parameter logic [31:0] DEFAULT_BYTES_PER_USEC = DFLT_BPU
) (
   input  logic                                  clk,
   input  logic                                  resetn,
   input  logic [31:0]                           S_AXI_AWADDR,
   input  logic [2:0]                            S_AXI_AWPROT,
   input  logic                                  S_AXI_AWVALID,
   output logic                                  S_AXI_AWREADY,
   input  logic [31:0]                           S_AXI_WDATA,
   input  logic [3:0]                            S_AXI_WSTRB,
   input  logic                                  S_AXI_WVALID,
   output logic                                  S_AXI_WREADY,
   output logic [1:0]                            S_AXI_BRESP,
   output logic                                  S_AXI_BVALID,
   input  logic                                  S_AXI_BREADY,
   input  logic [31:0]                           S_AXI_ARADDR,
   input  logic [2:0]                            S_AXI_ARPROT,
   input  logic                                  S_AXI_ARVALID,
   output logic                                  S_AXI_ARREADY,
   output logic [31:0]                           S_AXI_RDATA,
   output logic [1:0]                            S_AXI_RRESP,
   output logic                                  S_AXI_RVALID,
   input  logic                                  S_AXI_RREADY,
   input  logic [NUM_CHANNELS-1:0]               FRAME_BOUNDARY,
   output logic [NUM_CHANNELS*META_WORDS*32-1:0] METADATA,
   output logic [NUM_CHANNELS*32-1:0]            BYTES_PER_USEC,
   output logic [NUM_CHANNELS-1:0]               PENDING,
   output logic [NUM_CHANNELS-1:0]               COMMITTED
);

   localparam int CSW = idx_bits(NUM_CHANNELS);
   localparam int MIW = idx_bits(META_WORDS);

   logic [31:0] ashi_waddr, ashi_wdata, ashi_raddr, ashi_rdata;
   logic        ashi_write, ashi_read;
   logic [1:0]  ashi_wresp, ashi_rresp;

   logic [4:0]  widx, ridx;
   logic        wmeta_hit, rmeta_hit;
   logic        cs_we, bpu_we, meta_we;
   logic [NUM_CHANNELS-1:0] commit_mask, force_mask, do_copy, pending;
   logic [CSW-1:0]          chan_sel;

   logic [NUM_CHANNELS-1:0][META_WORDS-1:0][31:0] stg_meta_a, act_meta_a;
   logic [NUM_CHANNELS-1:0][31:0]                 stg_bpu_a, act_bpu_a;

   // Protection, strobes and the address bits above the register window
   // carry no meaning here.
   logic unused_sigs;
   assign unused_sigs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_WSTRB,
                          ashi_waddr[31:7], ashi_raddr[31:7]};

   axi4_lite_slave u_axi (
      .clk(clk), .resetn(resetn),
      .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
      .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
      .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
      .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
      .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP), .S_AXI_RVALID(S_AXI_RVALID),
      .S_AXI_RREADY(S_AXI_RREADY),
      .ASHI_WADDR(ashi_waddr), .ASHI_WDATA(ashi_wdata), .ASHI_WRITE(ashi_write),
      .ASHI_WRESP(ashi_wresp),
      .ASHI_RADDR(ashi_raddr), .ASHI_READ(ashi_read), .ASHI_RDATA(ashi_rdata),
      .ASHI_RRESP(ashi_rresp)
   );

   assign widx      = 5'((ashi_waddr[6:0] & ADDR_MASK) >> 2);
   assign ridx      = 5'((ashi_raddr[6:0] & ADDR_MASK) >> 2);
   assign wmeta_hit = (widx >= REG_META_BASE) && (int'(widx) < int'(REG_META_BASE) + META_WORDS);
   assign rmeta_hit = (ridx >= REG_META_BASE) && (int'(ridx) < int'(REG_META_BASE) + META_WORDS);

   // Write decode; response is valid whenever ASHI_WRITE is high,
   // side effects are gated by it.
   always_comb begin
      ashi_wresp  = RESP_DECERR;
      commit_mask = '0;
      force_mask  = '0;
      cs_we       = 1'b0;
      bpu_we      = 1'b0;
      meta_we     = 1'b0;
      case (widx)
         REG_COMMIT: begin
            ashi_wresp  = RESP_OKAY;
            commit_mask = ashi_wdata[NUM_CHANNELS-1:0];
         end
         REG_CHAN_SEL: begin
            if (ashi_wdata < 32'(NUM_CHANNELS)) begin
               ashi_wresp = RESP_OKAY;
               cs_we      = 1'b1;
            end else begin
               ashi_wresp = RESP_SLVERR;
            end
         end
`ifdef SIMFRAME_CFG_FORCE_EN
         REG_FORCE: begin
            ashi_wresp = RESP_OKAY;
            force_mask = ashi_wdata[NUM_CHANNELS-1:0];
         end
`endif
         REG_BPU: begin
            ashi_wresp = RESP_OKAY;
            bpu_we     = 1'b1;
         end
         default: begin
            if (wmeta_hit) begin
               ashi_wresp = RESP_OKAY;
               meta_we    = 1'b1;
            end
         end
      endcase
      if (!ashi_write) begin
         commit_mask = '0;
         force_mask  = '0;
         cs_we       = 1'b0;
         bpu_we      = 1'b0;
         meta_we     = 1'b0;
      end
   end

   // A boundary only consumes the already-registered PENDING, so a COMMIT
   // arriving with the boundary waits for the next one. FORCE overrides any
   // same-cycle COMMIT bit and leaves nothing pending.
   assign do_copy = (FRAME_BOUNDARY & pending) | force_mask;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         chan_sel <= '0;
         pending  <= '0;
      end else begin
         if (cs_we) chan_sel <= ashi_wdata[CSW-1:0];
         pending <= (pending & ~do_copy) | (commit_mask & ~force_mask);
      end
   end

   // Read data/response registered on the ASHI_READ strobe.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         ashi_rdata <= '0;
         ashi_rresp <= RESP_OKAY;
      end else if (ashi_read) begin
         ashi_rresp <= RESP_OKAY;
         case (ridx)
            REG_MODULE_REV: ashi_rdata <= MODULE_VERSION;
            REG_GEOMETRY:   ashi_rdata <= {16'(META_WORDS), 16'(NUM_CHANNELS)};
            REG_COMMIT:     ashi_rdata <= 32'(pending);
            REG_CHAN_SEL:   ashi_rdata <= 32'(chan_sel);
            REG_BPU:        ashi_rdata <= stg_bpu_a[chan_sel];
            REG_ACTIVE_BPU: ashi_rdata <= act_bpu_a[chan_sel];
            default: begin
               if (rmeta_hit) begin
                  ashi_rdata <= stg_meta_a[chan_sel][ridx[MIW-1:0]];
               end else begin
                  ashi_rdata <= '0;
                  ashi_rresp <= RESP_DECERR;
               end
            end
         endcase
      end
   end

   for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_chan
      simframe_cfg_chan #(
         .META_WORDS(META_WORDS),
         .DEFAULT_METADATA(DEFAULT_METADATA),
         .DEFAULT_BYTES_PER_USEC(DEFAULT_BYTES_PER_USEC)
      ) u_chan (
         .clk(clk),
         .resetn(resetn),
         .meta_we(meta_we && (chan_sel == CSW'(c))),
         .meta_widx(widx[MIW-1:0]),
         .bpu_we(bpu_we && (chan_sel == CSW'(c))),
         .wdata(ashi_wdata),
         .do_copy(do_copy[c]),
         .stg_meta(stg_meta_a[c]),
         .act_meta(act_meta_a[c]),
         .stg_bpu(stg_bpu_a[c]),
         .act_bpu(act_bpu_a[c]),
         .committed(COMMITTED[c])
      );
   end

   assign METADATA       = act_meta_a;
   assign BYTES_PER_USEC = act_bpu_a;
   assign PENDING        = pending;

endmodule

// File: tb/tb_simframe_config_mc.sv
// tb_simframe_config_mc: directed bench for simframe_config_mc (4 channels,
// 16 metadata words). Honours SIMFRAME_CFG_FORCE_EN for the FORCE checks.
module tb_simframe_config_mc;

   logic         clk = 1'b0;
   logic         resetn = 1'b0;
   logic [31:0]  awaddr = '0, wdata = '0, araddr = '0;
   logic         awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0;
   logic         awready, wready, bvalid, arready, rvalid;
   logic [1:0]   bresp, rresp;
   logic [31:0]  rdata;
   logic [3:0]   fb_in = '0;
   logic [2047:0] metadata;
   logic [127:0] bpu;
   logic [3:0]   pending, committed;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   simframe_config_mc dut (
      .clk(clk), .resetn(resetn),
      .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(3'd0), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
      .S_AXI_WDATA(wdata), .S_AXI_WSTRB(4'hF), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
      .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(1'b1),
      .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(3'd0), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
      .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(1'b1),
      .FRAME_BOUNDARY(fb_in), .METADATA(metadata), .BYTES_PER_USEC(bpu),
      .PENDING(pending), .COMMITTED(committed)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] meta(input int c, input int w);
      return metadata[(c*16+w)*32 +: 32];
   endfunction

   function automatic logic [31:0] bpu_of(input int c);
      return bpu[c*32 +: 32];
   endfunction

   // fb is driven for exactly the cycle in which the register write executes.
   task automatic axi_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] fb,
                         output logic [1:0] r, output logic [3:0] cm);
      int n;
      @(negedge clk);
      awaddr = a; wdata = d; awvalid = 1'b1; wvalid = 1'b1;
      n = 0;
      #1;
      while (!(awready && wready) && n < 20) begin @(negedge clk); #1; n++; end
      if (n >= 20) chk("aw_timeout", 32'(n), 32'd0);
      @(negedge clk);
      awvalid = 1'b0; wvalid = 1'b0; fb_in = fb;
      @(negedge clk);
      fb_in = '0;
      n = 0;
      while (!bvalid && n < 20) begin @(negedge clk); n++; end
      if (n >= 20) chk("b_timeout", 32'(n), 32'd0);
      r = bresp; cm = committed;
      @(negedge clk);
   endtask

   task automatic axi_rd(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r);
      int n;
      @(negedge clk);
      araddr = a; arvalid = 1'b1;
      n = 0;
      #1;
      while (!arready && n < 20) begin @(negedge clk); #1; n++; end
      if (n >= 20) chk("ar_timeout", 32'(n), 32'd0);
      @(negedge clk);
      arvalid = 1'b0;
      n = 0;
      while (!rvalid && n < 20) begin @(negedge clk); n++; end
      if (n >= 20) chk("r_timeout", 32'(n), 32'd0);
      d = rdata; r = rresp;
      @(negedge clk);
   endtask

   // Returns at the negedge after the sampling edge; cm is COMMITTED there.
   task automatic fb_pulse(input logic [3:0] m, output logic [3:0] cm);
      @(negedge clk);
      fb_in = m;
      @(negedge clk);
      fb_in = '0;
      cm = committed;
   endtask

   task automatic do_reset();
      @(negedge clk);
      resetn = 1'b0;
      repeat (2) @(negedge clk);
      resetn = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] d;
      logic [1:0]  r;
      logic [3:0]  cm;

      do_reset();
      // reset state
      chk("rst_pending", 32'(pending), 32'h0);
      chk("rst_committed", 32'(committed), 32'h0);
      chk("rst_meta_c3w0", meta(3, 0), 32'hBEEF_4200);
      chk("rst_meta_c0w1", meta(0, 1), 32'h0042_DEAD);
      chk("rst_meta_c1w2", meta(1, 2), 32'h0);
      chk("rst_bpu_c1", bpu_of(1), 32'd12288);
      axi_rd(32'h00, d, r); chk("rd_rev", d, 32'd2); chk("rd_rev_resp", 32'(r), 32'd0);
      axi_rd(32'h04, d, r); chk("rd_geom", d, 32'h0010_0004);
      axi_rd(32'h30, d, r); chk("rd_bpu", d, 32'd12288);
      axi_rd(32'h40, d, r); chk("rd_m0", d, 32'hBEEF_4200);
      axi_rd(32'h44, d, r); chk("rd_m1", d, 32'h0042_DEAD);
      axi_rd(32'h7C, d, r); chk("rd_m15", d, 32'h0); chk("rd_m15_resp", 32'(r), 32'd0);
      axi_rd(32'h0C, d, r); chk("rd_chsel_rst", d, 32'd0);

      // boundary without commit, then armed commit
      axi_wr(32'h0C, 32'd2, 4'h0, r, cm); chk("wr_chsel2", 32'(r), 32'd0);
      axi_wr(32'h40, 32'h1234, 4'h0, r, cm); chk("wr_m0", 32'(r), 32'd0);
      fb_pulse(4'h4, cm);
      chk("nocommit_cm", 32'(cm), 32'h0);
      chk("nocommit_meta", meta(2, 0), 32'hBEEF_4200);
      axi_wr(32'h08, 32'h4, 4'h0, r, cm);
      chk("commit_pend", 32'(pending), 32'h4);
      axi_rd(32'h08, d, r); chk("rd_commit", d, 32'h4);
      fb_pulse(4'h4, cm);
      chk("commit_cm", 32'(cm), 32'h4);
      chk("commit_meta", meta(2, 0), 32'h0000_1234);
      chk("commit_pend0", 32'(pending), 32'h0);
      chk("commit_other", meta(0, 0), 32'hBEEF_4200);
      @(negedge clk); chk("commit_cm_drop", 32'(committed), 32'h0);

      // out-of-range commit mask bits
      axi_wr(32'h08, 32'hFFFF_FFF0, 4'h0, r, cm);
      chk("commit_hi_pend", 32'(pending), 32'h0);

      // same-cycle interactions on channel 1
      axi_wr(32'h0C, 32'd1, 4'h0, r, cm);
      axi_wr(32'h40, 32'hAAAA, 4'h0, r, cm);
      axi_wr(32'h08, 32'h2, 4'h2, r, cm);
      chk("sim_nopend_cm", 32'(cm), 32'h0);
      chk("sim_nopend_meta", meta(1, 0), 32'hBEEF_4200);
      chk("sim_nopend_pend", 32'(pending), 32'h2);
      axi_wr(32'h40, 32'hBBBB, 4'h2, r, cm);
      chk("stgwr_cm", 32'(cm), 32'h2);
      chk("stgwr_meta_old", meta(1, 0), 32'h0000_AAAA);
      chk("stgwr_pend", 32'(pending), 32'h0);
      axi_wr(32'h08, 32'h2, 4'h0, r, cm);
      axi_wr(32'h08, 32'h2, 4'h2, r, cm);
      chk("sim_pend_cm", 32'(cm), 32'h2);
      chk("sim_pend_meta", meta(1, 0), 32'h0000_BBBB);
      chk("sim_pend_keep", 32'(pending), 32'h2);
      fb_pulse(4'h2, cm);
      chk("sim_pend_clr", 32'(pending), 32'h0);

      // error responses
      axi_wr(32'h0C, 32'd2, 4'h0, r, cm);
      axi_wr(32'h0C, 32'd4, 4'h0, r, cm); chk("chsel4_slverr", 32'(r), 32'd2);
      axi_rd(32'h0C, d, r); chk("chsel_kept", d, 32'd2);
      axi_rd(32'h14, d, r); chk("rd5_decerr", 32'(r), 32'd3);
      axi_wr(32'h34, 32'd1, 4'h0, r, cm); chk("wr13_decerr", 32'(r), 32'd3);
      axi_rd(32'h10, d, r); chk("rd4_decerr", 32'(r), 32'd3);

      // reset drops an armed commit
      axi_wr(32'h0C, 32'd1, 4'h0, r, cm);
      axi_wr(32'h30, 32'd5000, 4'h0, r, cm);
      axi_rd(32'h30, d, r); chk("rd_bpu_stg", d, 32'd5000);
      axi_rd(32'h34, d, r); chk("rd_actbpu", d, 32'd12288);
      axi_wr(32'h08, 32'h2, 4'h0, r, cm);
      chk("pre_rst_pend", 32'(pending), 32'h2);
      do_reset();
      chk("rst_pend_lost", 32'(pending), 32'h0);
      chk("rst_bpu_c1b", bpu_of(1), 32'd12288);
      chk("rst_meta_c1", meta(1, 0), 32'hBEEF_4200);
      axi_wr(32'h0C, 32'd1, 4'h0, r, cm);
      axi_rd(32'h30, d, r); chk("rst_rd_bpu", d, 32'd12288);

`ifdef SIMFRAME_CFG_FORCE_EN
      axi_wr(32'h0C, 32'd0, 4'h0, r, cm);
      axi_wr(32'h30, 32'd777, 4'h0, r, cm);
      axi_wr(32'h08, 32'h1, 4'h0, r, cm);
      axi_wr(32'h10, 32'h1, 4'h0, r, cm);
      chk("force_resp", 32'(r), 32'd0);
      chk("force_cm", 32'(cm), 32'h1);
      chk("force_bpu", bpu_of(0), 32'd777);
      chk("force_pend", 32'(pending), 32'h0);
      chk("force_cm_drop", 32'(committed), 32'h0);
`else
      axi_wr(32'h0C, 32'd0, 4'h0, r, cm);
      axi_wr(32'h30, 32'd777, 4'h0, r, cm);
      axi_wr(32'h10, 32'h1, 4'h0, r, cm);
      chk("force_decerr", 32'(r), 32'd3);
      chk("force_nocm", 32'(cm), 32'h0);
      chk("force_bpu_kept", bpu_of(0), 32'd12288);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/simframe_config_mc.md
Name: simframe_config_mc

Overview:
Multi-channel, parametrised successor to the single-channel simframe configuration block. It is an AXI4-Lite register file holding per-channel frame metadata and rate-limiter throughput (bytes/µs). All settings are double-buffered: software writes a staged copy, arms a commit, and each channel's active outputs update atomically only on that channel's frame boundary. It sits between the control-plane AXI interconnect and the N simframe generators, and connects through the existing axi4_lite_slave core (ASHI interface).

Parameters:
NUM_CHANNELS, 4, number of generator channels; legal range 1..32.
META_WORDS, 16, 32-bit metadata words per channel; legal range 1..16.
DEFAULT_METADATA, 64'h0042_DEAD_BEEF_4200, reset value of metadata words 0–1; higher words reset to 0.
DEFAULT_BYTES_PER_USEC, 12288, reset throughput for every channel.

Ports:
clk  in  1  clock
resetn  in  1  synchronous, active-low reset
S_AXI_*  AXI4-Lite slave, 32-bit address and data; same AW/W/B/AR/R signal set as the team's other AXI4-Lite slaves.
FRAME_BOUNDARY  in  NUM_CHANNELS  one-cycle pulse per channel; its generator is between frames.
METADATA  out  NUM_CHANNELS*META_WORDS*32  active metadata; channel c word w at bits [(c*META_WORDS+w)*32 +: 32].
BYTES_PER_USEC  out  NUM_CHANNELS*32  active throughput; channel c at [c*32 +: 32].
PENDING  out  NUM_CHANNELS  commit armed, not yet applied.
COMMITTED  out  NUM_CHANNELS  one-cycle pulse when staged→active copy occurs.

Behaviour:
- Reset: staged and active copies = defaults; PENDING=0; COMMITTED=0; CHAN_SEL=0; both ASHI state machines idle.
- Register map (index = (addr & 7'h7F)>>2):
  - 0 MODULE_REV: read-only, value 2.
  - 1 GEOMETRY: read-only, {META_WORDS[15:0], NUM_CHANNELS[15:0]}.
  - 2 COMMIT: write mask ORs into PENDING; mask bits ≥ NUM_CHANNELS are ignored; read returns PENDING zero-extended.
  - 3 CHAN_SEL: R/W. Write ≥ NUM_CHANNELS → SLVERR, value unchanged.
  - 12 BYTES_PER_USEC: R/W, staged value of the selected channel.
  - 13 ACTIVE_BPU: read-only, active value of the selected channel.
  - 16..16+META_WORDS-1: R/W, staged metadata of the selected channel.
  - Any other index, or a write to a read-only register → DECERR.
- Reads always return staged values except register 13. Read data and response are registered in the cycle ASHI_READ is high.
- Commit, per channel c, evaluated each cycle:
  - do_c = FRAME_BOUNDARY[c] & PENDING[c], using the registered PENDING value.
  - If do_c: active ← staged (all words plus BPU). Outputs change on the edge that samples the boundary. COMMITTED[c]=1 for exactly that cycle.
  - PENDING_next = (PENDING & ~do) | commit_write_mask.
- Simultaneous events:
  - COMMIT write and boundary in the same cycle with PENDING[c]=0: no copy; PENDING set; copy at the next boundary.
  - With PENDING[c]=1: copy occurs and PENDING stays 1.
  - Staged-data write in the same cycle as a copy: active receives the pre-write staged value.
- Boundary with PENDING=0: no effect.
- Reset mid-operation: PENDING is cleared and active returns to defaults immediately; an armed commit is lost.
- WSTRB is ignored; all writes are full-word.

Optional Feature:
SIMFRAME_CFG_FORCE_EN.
- Defined: register 4 FORCE (write-only). For each mask bit c < NUM_CHANNELS, active ← staged on the next edge, PENDING[c] clears, and COMMITTED[c] pulses. FORCE takes priority over a same-cycle COMMIT write for that channel.
- Undefined: index 4 decodes as DECERR; no force logic is synthesised.

Decomposition:
- Package simframe_cfg_pkg holds:
  - register index constants;
  - MODULE_VERSION=2;
  - response codes OKAY=0, SLVERR=2, DECERR=3;
  - ADDR_MASK=7'h7F;
  - the defaults.
- Sub-module simframe_cfg_chan: one channel's staged/active storage and commit logic. Instantiate it NUM_CHANNELS times in a generate loop.
- The top level holds ASHI decode, CHAN_SEL and PENDING, and the axi4_lite_slave instance.

Test Plan:
- Reset, then read regs 0, 1, 12, 16, 17 → 2, 0x0010_0004, 12288, 0xBEEF_4200, 0x0042_DEAD; METADATA ch3 word0 = 0xBEEF_4200.
- CHAN_SEL=2; write reg 16=0x1234; pulse FRAME_BOUNDARY[2] without commit → active unchanged. Write COMMIT=0x4, PENDING=0x4; pulse boundary[2] → METADATA ch2 word0=0x1234 next edge, COMMITTED[2] one cycle, PENDING=0.
- COMMIT=0x2 written the same cycle as FRAME_BOUNDARY[1] with PENDING=0 → no copy, PENDING=0x2; next boundary[1] copies.
- Write CHAN_SEL=4 (NUM_CHANNELS=4) → BRESP=SLVERR, readback 2. Read reg 5 → RRESP=DECERR. Write reg 13 → DECERR.
- CHAN_SEL=1, BPU=5000, COMMIT=0x2; reset asserted before the boundary → PENDING=0, BYTES_PER_USEC ch1=12288, reg 12 reads 12288.
- (FORCE_EN) CHAN_SEL=0, BPU=777, FORCE=0x1 → ch0 BPU=777 next edge without a boundary, COMMITTED[0] pulses; without the macro, the FORCE write → DECERR.
